// File: rtl/key_extractor_pkg.sv
// rtl/key_extractor_pkg.sv - shared widths, PHV/config field offsets and compare opcodes
package key_extractor_pkg;

  // Datapath widths
  localparam int CONT_W   = 128;  // one PHV container
  localparam int NUM_CONT = 8;    // containers C0..C7
  localparam int NUM_SLOT = 7;    // key slots
  localparam int CMP_W    = 16;   // compare operand width
  localparam int PROF_W   = 5;    // profile id / config address width
  localparam int STAGE_W  = 4;

  // PHV field offsets
  localparam int CONT_BASE = 555;  // C0 LSB; Ci = [CONT_BASE+128i +: 128]
  localparam int PROF_LSB  = 548;

  // Config entry field offsets
  localparam int SLOT_IDX_LSB = 32;  // slot k index = [SLOT_IDX_LSB+3k +: 3]
  localparam int SLOT_IDX_W   = 3;
  localparam int SLOT_EN_LSB  = 25;
  localparam int CONDA_LSB    = 22;
  localparam int CONDB_LSB    = 19;
  localparam int OP_LSB       = 17;
  localparam int IMM_SEL_BIT  = 16;
  localparam int IMM_LSB      = 0;

  typedef enum logic [1:0] {
    OP_ALWAYS = 2'b00,
    OP_EQ     = 2'b01,
    OP_GT     = 2'b10,
    OP_LT     = 2'b11
  } cmp_op_e;

endpackage

// File: rtl/key_extractor_if.sv
// rtl/key_extractor_if.sv - PHV in, key/PHV out and config-write bundle
// master: PHV source + config writer; slave: key_extractor
//   phv_in/phv_valid             PHV beat
//   extract_key/key_valid/cond_flag/pkt_hdr_vec  aligned key result
//   cfg_wr_en/cfg_wr_stage/cfg_wr_addr/cfg_wr_data  profile RAM write
interface key_extractor_if import key_extractor_pkg::*; #(
  parameter int PHV_LEN = 1579,
  parameter int KEY_LEN = 896,
  parameter int CFG_W   = 53
);
  logic [PHV_LEN-1:0] phv_in;
  logic               phv_valid;
  logic [KEY_LEN-1:0] extract_key;
  logic               key_valid;
  logic               cond_flag;
  logic [PHV_LEN-1:0] pkt_hdr_vec;
  logic               cfg_wr_en;
  logic [STAGE_W-1:0] cfg_wr_stage;
  logic [PROF_W-1:0]  cfg_wr_addr;
  logic [CFG_W-1:0]   cfg_wr_data;

  modport master (
    output phv_in, phv_valid, cfg_wr_en, cfg_wr_stage, cfg_wr_addr, cfg_wr_data,
    input  extract_key, key_valid, cond_flag, pkt_hdr_vec
  );

  modport slave (
    input  phv_in, phv_valid, cfg_wr_en, cfg_wr_stage, cfg_wr_addr, cfg_wr_data,
    output extract_key, key_valid, cond_flag, pkt_hdr_vec
  );
endinterface

// File: rtl/key_cfg_ram.sv
// rtl/key_cfg_ram.sv - simple dual-port profile RAM, registered read, old data on collision
// clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out one cycle later
module key_cfg_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 53,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read samples mem before this edge's write lands, so a same-address
  // collision returns the previous contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/key_extractor.sv
// rtl/key_extractor.sv - builds the 896-bit match key and cond_flag from the PHV, latency 2
// axis_clk, areset (async, active-high); bus: key_extractor_if.slave
module key_extractor import key_extractor_pkg::*; #(
  parameter int STAGE      = 0,
  parameter int PHV_LEN    = 1579,
  parameter int KEY_LEN    = 896,
  parameter int CFG_W      = 53,
  parameter int PROF_DEPTH = 32
) (
  input logic           axis_clk,
  input logic           areset,
  key_extractor_if.slave bus
);

  logic [PHV_LEN-1:0] phv_s1;
  logic               valid_s1;
  logic [CFG_W-1:0]   cfg;

  logic [CONT_W-1:0]  cont [NUM_CONT];
  logic [KEY_LEN-1:0] key_nxt;
  logic [CMP_W-1:0]   a_op;
  logic [CMP_W-1:0]   b_op;
  logic               flag_nxt;
  cmp_op_e            op;

  logic [KEY_LEN-1:0] key_q;
  logic [PHV_LEN-1:0] phv_q;
  logic               valid_q;
  logic               flag_q;

  // Profile lookup runs in parallel with the stage-1 PHV register, so the
  // entry and the PHV it belongs to meet in the same cycle.
  key_cfg_ram #(.DEPTH(PROF_DEPTH), .WIDTH(CFG_W), .AW(PROF_W)) u_cfg_ram (
    .clk    (axis_clk),
    .wr_en  (bus.cfg_wr_en && (bus.cfg_wr_stage == STAGE_W'(STAGE))),
    .wr_addr(bus.cfg_wr_addr),
    .wr_data(bus.cfg_wr_data),
    .rd_addr(bus.phv_in[PROF_LSB +: PROF_W]),
    .rd_data(cfg)
  );

  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      valid_s1 <= 1'b0;
      phv_s1   <= '0;
    end else begin
      valid_s1 <= bus.phv_valid;
      if (bus.phv_valid) phv_s1 <= bus.phv_in;
    end
  end

  always_comb begin
    key_nxt  = '0;
    flag_nxt = 1'b1;
    for (int i = 0; i < NUM_CONT; i++) begin
      cont[i] = phv_s1[CONT_BASE + i*CONT_W +: CONT_W];
    end
    for (int k = 0; k < NUM_SLOT; k++) begin
      if (cfg[SLOT_EN_LSB + k])
        key_nxt[k*CONT_W +: CONT_W] = cont[cfg[SLOT_IDX_LSB + SLOT_IDX_W*k +: SLOT_IDX_W]];
    end
    a_op = cont[cfg[CONDA_LSB +: 3]][CMP_W-1:0];
    b_op = cfg[IMM_SEL_BIT] ? cfg[IMM_LSB +: CMP_W] : cont[cfg[CONDB_LSB +: 3]][CMP_W-1:0];
    op   = cmp_op_e'(cfg[OP_LSB +: 2]);
    case (op)
      OP_ALWAYS: flag_nxt = 1'b1;
      OP_EQ:     flag_nxt = (a_op == b_op);
      OP_GT:     flag_nxt = (a_op >  b_op);
      OP_LT:     flag_nxt = (a_op <  b_op);
      default:   flag_nxt = 1'b1;
    endcase
  end

  // Key and forwarded PHV only update on a valid beat so downstream sees
  // stable values between beats; the flag is qualified by valid.
  always_ff @(posedge axis_clk or posedge areset) begin
    if (areset) begin
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      key_q   <= '0;
      phv_q   <= '0;
    end else begin
      valid_q <= valid_s1;
      flag_q  <= valid_s1 & flag_nxt;
      if (valid_s1) begin
        key_q <= key_nxt;
        phv_q <= phv_s1;
      end
    end
  end

  assign bus.extract_key = key_q;
  assign bus.pkt_hdr_vec = phv_q;
  assign bus.key_valid   = valid_q;
  assign bus.cond_flag   = flag_q;

endmodule

// File: tb/tb_key_extractor.sv
// tb/tb_key_extractor.sv - self-checking bench for key_extractor
module tb_key_extractor;

  typedef struct {
    int           due;
    logic [895:0] key;
    bit           flag;
    logic [1578:0] phv;
  } exp_t;

  typedef struct {
    logic [4:0]  prof;
    logic [2:0]  ai;
    logic [2:0]  bi;
    logic [15:0] a;
    logic [15:0] b;
    bit          exp_flag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  logic [52:0]  model_cfg [32];
  exp_t         q [$];
  logic [895:0]  last_key = '0;
  logic [1578:0] last_phv = '0;

  key_extractor_if bus ();

  key_extractor #(.STAGE(0)) dut (
    .axis_clk(clk),
    .areset  (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int w;
    n_vec++;
    if (act !== exp) begin
      w = 0;
      for (int i = 49; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      n_miss++;
      $display("FAIL %s @cyc %0d: word %0d got %h expected %h", name, cyc, w,
               act[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  function automatic logic [127:0] cont_of(input logic [1578:0] p, input int i);
    logic [1578:0] t;
    t = p >> (555 + 128*i);
    return t[127:0];
  endfunction

  function automatic logic [895:0] model_key(input logic [1578:0] p, input logic [52:0] c);
    logic [895:0] k;
    k = '0;
    for (int s = 0; s < 7; s++)
      if (c[25 + s]) k[128*s +: 128] = cont_of(p, int'(c[32 + 3*s +: 3]));
    return k;
  endfunction

  function automatic bit model_flag(input logic [1578:0] p, input logic [52:0] c);
    logic [127:0] ca, cb;
    int unsigned a, b;
    ca = cont_of(p, int'(c[24:22]));
    cb = cont_of(p, int'(c[21:19]));
    a = ca[15:0];
    b = c[16] ? c[15:0] : cb[15:0];
    case (c[18:17])
      2'b00:   return 1'b1;
      2'b01:   return a == b;
      2'b10:   return a > b;
      default: return a < b;
    endcase
  endfunction

  function automatic logic [52:0] mk_cfg(input logic [20:0] idx, input logic [6:0] en,
                                         input logic [2:0] ca, input logic [2:0] cb,
                                         input logic [1:0] op, input bit isel,
                                         input logic [15:0] imm);
    return {idx, en, ca, cb, op, isel, imm};
  endfunction

  function automatic logic [1578:0] rand_phv(input logic [4:0] prof);
    logic [1599:0] t;
    for (int i = 0; i < 50; i++) t[i*32 +: 32] = $urandom;
    t[552:548] = prof;
    return t[1578:0];
  endfunction

  // One input cycle: expectation is taken from the model before any write
  // of this same cycle is applied (old data on read/write collision).
  task automatic drive(input bit wr, input logic [3:0] stg, input logic [4:0] waddr,
                       input logic [52:0] wdata, input bit v, input logic [1578:0] p,
                       input int fo);
    exp_t e;
    logic [4:0] prof;
    @(posedge clk); #1;
    bus.cfg_wr_en    = wr;
    bus.cfg_wr_stage = stg;
    bus.cfg_wr_addr  = waddr;
    bus.cfg_wr_data  = wdata;
    bus.phv_valid    = v;
    bus.phv_in       = p;
    if (v) begin
      prof   = p[552:548];
      e.due  = cyc + 2;
      e.key  = model_key(p, model_cfg[prof]);
      e.flag = (fo < 0) ? model_flag(p, model_cfg[prof]) : fo[0];
      e.phv  = p;
      q.push_back(e);
    end
    if (wr && stg == 4'd0) model_cfg[waddr] = wdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b0, rand_phv(5'd0), -1);
  endtask

  task automatic write_cfg(input logic [4:0] a, input logic [52:0] d);
    drive(1'b1, 4'd0, a, d, 1'b0, rand_phv(5'd0), -1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   exp_v;
    if (rst) begin
      check("rst_key_valid", {1599'd0, bus.key_valid}, 1600'd0);
      check("rst_cond_flag", {1599'd0, bus.cond_flag}, 1600'd0);
      check("rst_extract_key", {704'd0, bus.extract_key}, 1600'd0);
      check("rst_pkt_hdr_vec", {21'd0, bus.pkt_hdr_vec}, 1600'd0);
      last_key = '0;
      last_phv = '0;
    end else begin
      exp_v = 1'b0;
      if (q.size() > 0) if (q[0].due == cyc) exp_v = 1'b1;
      check("key_valid", {1599'd0, bus.key_valid}, {1599'd0, exp_v});
      if (exp_v) begin
        e = q.pop_front();
        check("extract_key", {704'd0, bus.extract_key}, {704'd0, e.key});
        check("cond_flag", {1599'd0, bus.cond_flag}, {1599'd0, e.flag});
        check("pkt_hdr_vec", {21'd0, bus.pkt_hdr_vec}, {21'd0, e.phv});
        last_key = e.key;
        last_phv = e.phv;
      end else begin
        check("idle_cond_flag", {1599'd0, bus.cond_flag}, 1600'd0);
        check("hold_extract_key", {704'd0, bus.extract_key}, {704'd0, last_key});
        check("hold_pkt_hdr_vec", {21'd0, bus.pkt_hdr_vec}, {21'd0, last_phv});
      end
    end
  end

  initial begin
    vec_t          vecs [9];
    logic [1578:0] p;
    logic [52:0]   cfg_a, cfg_b, cfg_c;
    logic [63:0]   r64;

    bus.phv_in = '0; bus.phv_valid = 0; bus.cfg_wr_en = 0;
    bus.cfg_wr_stage = '0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
    for (int i = 0; i < 32; i++) model_cfg[i] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Profile 3: slot 0 <- C7, always-true condition
    write_cfg(5'd3, mk_cfg({18'd0, 3'd7}, 7'h01, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0));
    p = rand_phv(5'd3);
    p[555 + 7*128 +: 128] = {8'hFF, 120'h0};
    drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, p, 1);
    idle(3);

    // Table-driven compare vectors; entries for the same profile run back-to-back
    write_cfg(5'd1, mk_cfg(21'd0, 7'h01, 3'd2, 3'd0, 2'b01, 1'b1, 16'h0800));
    write_cfg(5'd2, mk_cfg(21'd0, 7'h03, 3'd0, 3'd1, 2'b10, 1'b0, 16'h0));
    write_cfg(5'd5, mk_cfg({18'd0, 3'd3}, 7'h01, 3'd3, 3'd4, 2'b11, 1'b0, 16'h0));
    vecs[0] = '{5'd1, 3'd2, 3'd5, 16'h0800, 16'h0000, 1'b1};
    vecs[1] = '{5'd1, 3'd2, 3'd5, 16'h86DD, 16'h0800, 1'b0};
    vecs[2] = '{5'd2, 3'd0, 3'd1, 16'd5,    16'd3,    1'b1};
    vecs[3] = '{5'd2, 3'd0, 3'd1, 16'd3,    16'd5,    1'b0};
    vecs[4] = '{5'd2, 3'd0, 3'd1, 16'd4,    16'd4,    1'b0};
    vecs[5] = '{5'd5, 3'd3, 3'd4, 16'd1,    16'd2,    1'b1};
    vecs[6] = '{5'd5, 3'd3, 3'd4, 16'd2,    16'd1,    1'b0};
    vecs[7] = '{5'd5, 3'd3, 3'd4, 16'hFFFF, 16'h0000, 1'b0};
    vecs[8] = '{5'd5, 3'd3, 3'd4, 16'h0000, 16'hFFFF, 1'b1};
    for (int i = 0; i < 9; i++) begin
      p = rand_phv(vecs[i].prof);
      p[555 + 128*int'(vecs[i].ai) +: 16] = vecs[i].a;
      p[555 + 128*int'(vecs[i].bi) +: 16] = vecs[i].b;
      drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, p, int'(vecs[i].exp_flag));
    end
    idle(3);

    // Stage filter and read-during-write on profile 4
    cfg_a = mk_cfg({18'd0, 3'd1}, 7'h01, 3'd1, 3'd0, 2'b01, 1'b1, 16'h1234);
    cfg_b = mk_cfg({18'd0, 3'd5}, 7'h01, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0);
    cfg_c = mk_cfg({18'd0, 3'd6}, 7'h41, 3'd0, 3'd0, 2'b00, 1'b0, 16'h0);
    write_cfg(5'd4, cfg_a);
    drive(1'b1, 4'd5, 5'd4, cfg_b, 1'b0, rand_phv(5'd0), -1);
    drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, rand_phv(5'd4), -1);
    drive(1'b1, 4'd0, 5'd4, cfg_c, 1'b1, rand_phv(5'd4), -1);
    drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, rand_phv(5'd4), -1);
    idle(3);

    // Reset one cycle after an accepted beat: the beat must vanish
    drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, rand_phv(5'd3), -1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.phv_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // All seven slots, slot k <- Ck, distinct container patterns
    write_cfg(5'd6, mk_cfg({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 7'h7F,
                           3'd0, 3'd1, 2'b11, 1'b0, 16'h0));
    p = rand_phv(5'd6);
    for (int i = 0; i < 8; i++) p[555 + 128*i +: 128] = {16{8'(8'h11 * (i + 1))}};
    drive(1'b0, 4'd0, 5'd0, 53'd0, 1'b1, p, -1);
    idle(3);

    // Randomized traffic over profiles 8..15 with occasional config writes
    for (int i = 8; i < 16; i++) begin
      r64 = {$urandom, $urandom};
      write_cfg(5'(i), r64[52:0]);
    end
    for (int n = 0; n < 300; n++) begin
      bit          v, wr;
      logic [3:0]  stg;
      v   = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 7) == 0);
      stg = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      r64 = {$urandom, $urandom};
      drive(wr, stg, 5'(8 + $urandom_range(0, 7)), r64[52:0], v,
            rand_phv(5'(8 + $urandom_range(0, 7))), -1);
    end
    idle(4);

    check("queue_drained", 1600'(q.size()), 1600'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_extractor.md
Name: key_extractor

Overview:
- Match-stage front end directly upstream of lookup_engine.
- Takes the packet header vector (PHV) and uses a per-profile configuration RAM to build the 896-bit match key from PHV containers.
- Evaluates one compare condition to produce cond_flag.
- Forwards the PHV aligned with the key; output feeds lookup_engine's extract_key/key_valid/cond_flag/pkt_hdr_vec.

Parameters:
- STAGE, 0, pipeline stage index; compared against cfg_wr_stage so only this stage's RAM is written.
- PHV_LEN, 1579, PHV width.
- KEY_LEN, 896, key width (7 slots x 128 bits).
- CFG_W, 53, configuration entry width.
- PROF_DEPTH, 32, number of profiles (5-bit address).

Ports:
- axis_clk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- phv_in  in  PHV_LEN  input header vector
- phv_valid  in  1  phv_in valid, single-cycle qualifier
- extract_key  out  KEY_LEN  assembled key
- key_valid  out  1  key/PHV valid
- cond_flag  out  1  condition result
- pkt_hdr_vec  out  PHV_LEN  PHV delayed to align with key
- cfg_wr_en  in  1  config write strobe
- cfg_wr_stage  in  4  target stage
- cfg_wr_addr  in  5  profile index
- cfg_wr_data  in  CFG_W  entry

Behaviour:
- PHV map, MSB first:
  - [1578:555] 8 containers C7..C0, 128 bits each; C7 = [1578:1451].
  - [554:548] 7-bit tag; profile id = [552:548].
  - Remainder is carried unused.
- Config entry fields, MSB first:
  - slot_idx[6..0], 3 bits each = [52:32].
  - slot_en[6:0] = [31:25].
  - condA idx = [24:22].
  - condB idx = [21:19].
  - op = [18:17].
  - imm_sel = [16].
  - imm = [15:0].
- Key: slot k occupies extract_key[128k+127:128k] = slot_en[k] ? C[slot_idx[k]] : 0.
- Condition operands:
  - A = C[condA][15:0].
  - B = imm_sel ? imm : C[condB][15:0].
- op encoding:
  - 00: flag = 1 (always).
  - 01: flag = A == B.
  - 10: flag = A > B (unsigned).
  - 11: flag = A < B (unsigned).
- Pipeline, fixed latency 2, no backpressure, one PHV per cycle accepted:
  - Cycle T: phv_valid high. Profile id addresses the RAM (registered read). phv_in and valid go to stage-1 registers.
  - Cycle T+1: the RAM entry plus stage-1 PHV compute the key and cond. These are registered into the outputs.
  - Cycle T+2: key_valid=1 with extract_key, cond_flag, pkt_hdr_vec valid for exactly one cycle per input beat.
- Back-to-back inputs give back-to-back outputs in order.
- When key_valid=0:
  - pkt_hdr_vec and extract_key hold their last values.
  - cond_flag is forced to 0.
- Config write:
  - Takes effect on the rising edge when cfg_wr_en=1 and cfg_wr_stage==STAGE. Ignored otherwise.
  - Read-during-write to the same address returns OLD data.
  - A PHV whose phv_valid arrives one or more cycles after the write cycle sees the new entry.
- Reset (async assert, sync-safe deassert):
  - key_valid=0, cond_flag=0, extract_key=0, pkt_hdr_vec=0, pipeline valid bits cleared.
  - Config RAM is not cleared.
- Reset mid-packet: in-flight beats are dropped; no output valid follows the reset release for beats accepted before reset.
- Unwritten profiles: output content is undefined but key_valid timing is unaffected.

Decomposition:
- Package key_extractor_pkg holds:
  - Widths: CONT_W=128, NUM_CONT=8, NUM_SLOT=7, CMP_W=16.
  - PHV field offsets: CONT_BASE=555, PROF_LSB=548.
  - Config field offsets.
  - op encodings: OP_ALWAYS, OP_EQ, OP_GT, OP_LT.
- One sub-module: key_cfg_ram, a 32 x CFG_W simple dual-port RAM with a registered read (1-cycle latency), old-data-on-collision behaviour, and no reset.

Test Plan:
1. Write profile 3: slot_idx[0]=7, slot_en=7'b0000001, op=00. Send PHV with C7=128'hFF00..00 and profile 3 -> two cycles later key_valid=1, extract_key[127:0]=C7, upper 768 bits 0, cond_flag=1.
2. Profile 1 with op=01, imm_sel=1, imm=16'h0800, condA=2:
   - C2[15:0]=16'h0800 -> cond_flag=1.
   - Repeat with 16'h86DD -> cond_flag=0.
3. Profile 2 with op=10, condA=0, condB=1. Three back-to-back beats, (A,B) = (5,3), (3,5), (4,4) -> cond_flag = 1,0,0 on consecutive cycles; key_valid high for 3 cycles.
4. Write profile 4 with cfg_wr_stage != STAGE -> no effect on profile 4 output. Write profile 4 in the same cycle a PHV with profile 4 is accepted -> that beat uses old data, and the next beat uses new data.
5. Assert areset one cycle after phv_valid -> key_valid stays 0 through and after reset, and all outputs read 0 during reset.
6. Profile with all 7 slots enabled, slot_idx = 6..0, containers filled with distinct patterns -> extract_key equals {C6..C0}, with the forwarded PHV bit-identical to the input.
